instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- IF stage of the five-stage MIPS pipeline. Owns the PC and the instruction memory, and produces the IF/ID register (instruction word plus PC+4).
- The control unit decodes the opcode/funct fields from that register.
- Consumes the decode-side results: stall, branch/jump/jr/jal redirect, and PC_end halt.
- Program load runs through a write port while idle; execution starts on a start pulse.

Parameters:
- ADDR_W, 10, instruction memory word-address width (2^ADDR_W 32-bit words).
- DATA_W, 32, instruction and PC width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_load_we  in  1  program-load write strobe; honoured only in IDLE.
- i_load_addr  in  ADDR_W  word address for the load write.
- i_load_data  in  DATA_W  instruction word to write.
- i_start  in  1  one-cycle pulse; IDLE -> RUN.
- i_stall  in  1  hazard-unit stall; holds PC and IF/ID.
- i_redirect  in  1  taken beq/bne, j, jal, jr or jalr resolved in ID.
- i_redirect_pc  in  DATA_W  byte address of the redirect target.
- i_halt  in  1  PC_end decoded in ID.
- o_instr  out  DATA_W  IF/ID instruction register.
- o_pc_plus4  out  DATA_W  IF/ID PC+4 register.
- o_valid  out  1  o_instr holds a real fetched instruction (0 = bubble).
- o_state  out  2  FSM state.
- o_halted  out  1  high while in HALT.

Behaviour:
- Reset (synchronous, priority over everything):
  - pc=0, o_instr=0 (NOP), o_pc_plus4=0, o_valid=0, state=IDLE, o_halted=0.
  - Memory contents are not cleared.
- Memory:
  - Write is synchronous, and happens only when state==IDLE and i_load_we=1.
  - Read is asynchronous at word index pc[ADDR_W+1:2]. Higher PC bits are ignored (wrap-around); pc[1:0] are ignored.
- FSM states: IDLE=00, RUN=01, HALT=10.
  - IDLE: pc held at 0, IF/ID holds NOP with valid=0. i_start=1 -> RUN next cycle.
  - RUN: each cycle, evaluate in priority order:
    1. i_stall=1: pc, o_instr, o_pc_plus4 and o_valid all hold. Redirect and halt are ignored this cycle, because ID holds the instruction and re-presents them.
    2. i_halt=1: -> HALT. pc holds, o_instr<=0, o_valid<=0 (flushes the instruction fetched after halt).
    3. i_redirect=1: pc<=i_redirect_pc with bits [1:0] forced to 0. o_instr<=0, o_valid<=0 (one-cycle bubble). o_pc_plus4 holds.
    4. Otherwise: o_instr<=mem[pc], o_pc_plus4<=pc+4, o_valid<=1, pc<=pc+4 (modulo 2^DATA_W).
  - HALT: every register holds and o_halted=1. Only reset leaves HALT. i_start and i_load_we are ignored.
- i_start in RUN or HALT: ignored. i_load_we outside IDLE: ignored, memory unchanged.
- Latency: a word fetched at pc appears on o_instr one cycle later. A redirect costs exactly one bubble cycle.

Decomposition:
- Shared package holds:
  - FSM state encodings.
  - NOP constant 32'h00000000.
  - Opcode constants already used by decode (R_type, lw, sw, beq, bne, j, jal, addi, halt=6'b111111), so benches and fetch share one source.
- One sub-module: instr_mem. Single synchronous write port, single asynchronous read port, parameterised by ADDR_W and DATA_W.

Test Plan:
- Load sequence:
  - Stimulus: reset; load 0x20010005, 0x20020007, 0xFC000000 at words 0-2; pulse start.
  - Response: o_instr/o_pc_plus4 = 0x20010005/4, then 0x20020007/8, then 0xFC000000/12.
  - Then assert i_halt one cycle: state=HALT, o_valid=0, o_halted=1, and pc frozen in every later cycle.
- Stall:
  - Stimulus: i_stall high 2 cycles while o_instr=0x20020007.
  - Response: o_instr, o_pc_plus4=8 and o_valid=1 are unchanged both cycles; the next cycle shows word 2 with o_pc_plus4=12.
- Redirect:
  - Stimulus: i_redirect with i_redirect_pc=0x43.
  - Response: the next cycle gives o_instr=0 and o_valid=0; the following cycle gives o_instr=mem[16] and o_pc_plus4=0x44.
- Stall + redirect together:
  - Stimulus: both asserted in the same cycle.
  - Response: stall wins and nothing changes; with redirect alone on the next cycle, target 0x40 is applied.
- Load gating:
  - Stimulus: i_load_we to word 1 with 0xDEADBEEF during RUN.
  - Response: a later reset+start run fetches the original word 1. The same write done in IDLE fetches 0xDEADBEEF.
- Reset mid-run:
  - Stimulus: assert reset at pc=0x20.
  - Response: the next cycle gives pc=0, o_instr=0, o_valid=0, state=IDLE; after start, the first fetch is the unchanged mem[0].

Source files
------------

// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, the NOP word and
// the opcode constants that decode and the benches also rely on.
package instr_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_HALT   = 6'b111111;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: program-load port,
// decode-side control inputs and the IF/ID register outputs.
interface instr_fetch_stage_if
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              i_load_we;
  logic [ADDR_W-1:0] i_load_addr;
  logic [DATA_W-1:0] i_load_data;
  logic              i_start;
  logic              i_stall;
  logic              i_redirect;
  logic [DATA_W-1:0] i_redirect_pc;
  logic              i_halt;
  logic [DATA_W-1:0] o_instr;
  logic [DATA_W-1:0] o_pc_plus4;
  logic              o_valid;
  state_t            o_state;
  logic              o_halted;

  modport master (
    output i_load_we, i_load_addr, i_load_data, i_start,
           i_stall, i_redirect, i_redirect_pc, i_halt,
    input  o_instr, o_pc_plus4, o_valid, o_state, o_halted
  );

  modport slave (
    input  i_load_we, i_load_addr, i_load_data, i_start,
           i_stall, i_redirect, i_redirect_pc, i_halt,
    output o_instr, o_pc_plus4, o_valid, o_state, o_halted
  );
endinterface

// File: rtl/instr_fetch_stage_instr_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
module instr_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Program-load write; contents are deliberately not touched by reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC and instruction memory and produces the IF/ID
// register (instruction word, PC+4, valid).
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  instr_fetch_stage_if.slave  bus
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;

  assign mem_we = (state_q == ST_IDLE) && bus.i_load_we;

  instr_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (bus.i_load_addr),
    .wdata (bus.i_load_data),
    .raddr (pc_q[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next IF/ID contents; stall outranks halt outranks redirect
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        pc_d    = '0;
        instr_d = DATA_W'(NOP);
        valid_d = 1'b0;
        if (bus.i_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_stall) begin
          // ID re-presents redirect/halt once the stall clears
        end else if (bus.i_halt) begin
          state_d = ST_HALT;
          instr_d = DATA_W'(NOP);
          valid_d = 1'b0;
        end else if (bus.i_redirect) begin
          pc_d    = bus.i_redirect_pc & ~DATA_W'(3);
          instr_d = DATA_W'(NOP);
          valid_d = 1'b0;
        end else begin
          instr_d = mem_rdata;
          pc4_d   = pc_q + DATA_W'(4);
          valid_d = 1'b1;
          pc_d    = pc_q + DATA_W'(4);
        end
      end
      ST_HALT: begin
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC and IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= DATA_W'(NOP);
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.o_instr    = instr_q;
  assign bus.o_pc_plus4 = pc4_q;
  assign bus.o_valid    = valid_q;
  assign bus.o_state    = state_q;
  assign bus.o_halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios followed by random
// traffic, all compared cycle by cycle against a behavioural model.
module tb_instr_fetch_stage;
  import instr_fetch_stage_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WORDS  = 2**ADDR_W;

  logic clk = 1'b0;
  logic reset;

  instr_fetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Behavioural model: 0 = idle, 1 = running, 2 = halted
  logic [31:0] m_mem [WORDS];
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int unsigned m_mode;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (bus.i_load_we) m_mem[bus.i_load_addr] = bus.i_load_data;
      if (bus.i_start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (bus.i_stall) begin
      end else if (bus.i_halt) begin
        m_mode = 2; m_instr = 0; m_valid = 0;
      end else if (bus.i_redirect) begin
        m_pc = (bus.i_redirect_pc / 4) * 4;
        m_instr = 0; m_valid = 0;
      end else begin
        m_instr = m_mem[(m_pc / 4) % WORDS];
        m_pc    = m_pc + 4;
        m_pc4   = m_pc;
        m_valid = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("instr",  bus.o_instr, m_instr);
    chk("pc4",    bus.o_pc_plus4, m_pc4);
    chk("valid",  32'(bus.o_valid), 32'(m_valid));
    chk("state",  32'(bus.o_state), m_mode);
    chk("halted", 32'(bus.o_halted), 32'(m_mode == 2));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    reset = 0;
    bus.i_load_we = 0; bus.i_load_addr = '0; bus.i_load_data = '0;
    bus.i_start = 0; bus.i_stall = 0; bus.i_redirect = 0;
    bus.i_redirect_pc = '0; bus.i_halt = 0;
  endtask

  task automatic do_reset();
    quiet(); reset = 1; tick(); reset = 0;
  endtask

  task automatic do_start();
    quiet(); bus.i_start = 1; tick(); bus.i_start = 0;
  endtask

  task automatic load(input int unsigned addr, input logic [31:0] data);
    quiet();
    bus.i_load_we = 1; bus.i_load_addr = ADDR_W'(addr); bus.i_load_data = data;
    tick();
    bus.i_load_we = 0;
  endtask

  initial begin
    quiet();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mode = 0;

    // Reset state
    do_reset();
    chk("rst_instr", bus.o_instr, 32'h0);
    chk("rst_valid", 32'(bus.o_valid), 32'h0);
    chk("rst_state", 32'(bus.o_state), 32'h0);

    // Fill the whole memory so every fetch hits a known word
    for (int unsigned a = 0; a < WORDS; a++) load(a, $urandom);
    load(0, 32'h2001_0005);
    load(1, 32'h2002_0007);
    load(2, {OP_HALT, 26'h0});

    // Load sequence, then halt
    do_start();
    tick(); chk("seq_w0", bus.o_instr, 32'h2001_0005); chk("seq_p0", bus.o_pc_plus4, 32'd4);
    tick(); chk("seq_w1", bus.o_instr, 32'h2002_0007); chk("seq_p1", bus.o_pc_plus4, 32'd8);
    tick(); chk("seq_w2", bus.o_instr, 32'hFC00_0000); chk("seq_p2", bus.o_pc_plus4, 32'd12);
    bus.i_halt = 1; tick(); bus.i_halt = 0;
    chk("halt_state", 32'(bus.o_state), 32'h2);
    for (int i = 0; i < 6; i++) begin
      bus.i_start = 1'($urandom); bus.i_load_we = 1'($urandom);
      bus.i_load_addr = ADDR_W'($urandom); bus.i_load_data = $urandom;
      tick();
    end
    chk("halt_hold", 32'(bus.o_halted), 32'h1);

    // Stall while word 1 is in IF/ID
    do_reset(); do_start(); tick(); tick();
    bus.i_stall = 1; tick(); tick(); bus.i_stall = 0;
    chk("stall_pc4", bus.o_pc_plus4, 32'd8);
    tick(); chk("post_stall_pc4", bus.o_pc_plus4, 32'd12);

    // Redirect to an unaligned target, one bubble
    bus.i_redirect = 1; bus.i_redirect_pc = 32'h43; tick(); bus.i_redirect = 0;
    chk("redir_bubble", 32'(bus.o_valid), 32'h0);
    tick(); chk("redir_pc4", bus.o_pc_plus4, 32'h44);

    // Stall and redirect together: stall wins, then redirect alone
    bus.i_stall = 1; bus.i_redirect = 1; bus.i_redirect_pc = 32'h40; tick();
    bus.i_stall = 0; tick(); bus.i_redirect = 0;
    tick(); chk("sr_pc4", bus.o_pc_plus4, 32'h44);

    // Load gating: write during RUN ignored, write in IDLE honoured
    load(1, 32'hDEAD_BEEF);
    do_reset(); do_start(); tick(); tick();
    chk("gate_run", bus.o_instr, 32'h2002_0007);
    do_reset(); load(1, 32'hDEAD_BEEF); do_start(); tick(); tick();
    chk("gate_idle", bus.o_instr, 32'hDEAD_BEEF);

    // Reset once pc has reached 0x20
    do_reset(); do_start();
    for (int i = 0; i < 8; i++) tick();
    do_reset();
    chk("midrst_state", 32'(bus.o_state), 32'h0);
    do_start(); tick(); chk("midrst_w0", bus.o_instr, 32'h2001_0005);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      quiet();
      reset             = ($urandom_range(99) == 0);
      bus.i_start       = ($urandom_range(9) == 0);
      bus.i_stall       = ($urandom_range(9) < 3);
      bus.i_redirect    = ($urandom_range(19) < 3);
      bus.i_redirect_pc = $urandom;
      bus.i_halt        = ($urandom_range(49) == 0);
      bus.i_load_we     = ($urandom_range(4) == 0);
      bus.i_load_addr   = ADDR_W'($urandom);
      bus.i_load_data   = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
